mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Sequencing state machine for the multi-cycle MIPS core. It holds the 4-bit control state and advances it using the IR opcode and funct fields. It sits directly upstream of the control-output decoder, which turns the state plus opcode, funct and zero into PCWr, IRWr, RegWr, MemWr and related strobes. It also handles the data-memory ready handshake, flags unsupported instructions, and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  core clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
opcode  input  6  IR[31:26]; stable from ID onward.
funct  input  6  IR[5:0]; meaningful only when opcode==000000.
mem_rdy  input  1  data memory completes the access this cycle; tie to 1 for single-cycle memory.
state  output  4  current control state, fed to the output decoder.
instr_done  output  1  combinational; high in the final cycle of an instruction.
illegal  output  1  registered one-cycle pulse for an unsupported instruction.
retired  output  CNT_W  count of completed instructions; wraps.

Behaviour:
- State encoding: IF=0000, ID=0001, MA=0010, MR=0011, MemWB=0100, MW=0101, Exe=0110, WB=0111, Branch=1000, Jump=1001.
- Codes 1010 through 1111 are unreachable. If entered, next state is IF, with no illegal pulse and no count.
- Reset:
  - state=IF, illegal=0, retired=0.
  - Reset mid-instruction discards the instruction: the next cycle is IF with the counter cleared.
  - Reset takes priority over every transition.
- Transitions, one per clock unless stated:
  - IF -> ID.
  - ID, lw(100011), lb(100000), sw(101011), sb(101000) -> MA.
  - ID, addi(001000), addiu(001001), ori(001101), lui(001111) -> Exe.
  - ID, opcode 000000 with funct addu(100001), subu(100011), slt(101010) -> Exe.
  - ID, beq(000100) -> Branch.
  - ID, j(000010), jal(000011) -> Jump.
  - ID, opcode 000000 with funct jr(001000), jalr(001001) -> Jump.
  - ID, any other opcode/funct combination -> IF; illegal=1 during that IF cycle.
  - MA, lw/lb -> MR; MA, sw/sb -> MW.
  - MA with any other opcode -> IF. This path is defensive only and produces no pulse and no count.
  - MR: hold while mem_rdy=0; go to MemWB when mem_rdy=1.
  - MemWB -> IF.
  - MW: hold while mem_rdy=0; go to IF when mem_rdy=1.
  - Exe -> WB -> IF.
  - Branch -> IF.
  - Jump -> IF.
- instr_done is high when the state is one of:
  - MemWB, WB, Branch or Jump;
  - MW with mem_rdy=1.
  It is never high in IF, ID, MA or Exe, and never for an illegal instruction.
- retired increments by 1 on the clock edge where instr_done=1. From all-ones it wraps to 0 with no flag.
- illegal is set for exactly one cycle (the IF following the offending ID) and is otherwise 0. It does not affect retired.
- Cycles per instruction with mem_rdy=1:
  - R-type and immediate ALU instructions: 4.
  - lw/lb: 5.
  - sw/sb: 4.
  - beq: 3.
  - j/jal/jr/jalr: 3.
  - Illegal: 2.
  - Each cycle mem_rdy=0 in MR or MW adds one cycle.
- mem_rdy is ignored in every state other than MR and MW.
- opcode and funct are sampled only in ID and MA. Changes to them in other states have no effect.
- No combinational path from the inputs to state. instr_done depends combinationally on state and mem_rdy only.

Test Plan:
- Reset, then addu (opcode 000000, funct 100001), mem_rdy=1 -> state 0,1,6,7,0; instr_done high only in the WB cycle; retired=1.
- lw (100011) with mem_rdy low for 2 MR cycles -> state 0,1,2,3,3,3,4,0; instr_done in MemWB only; retired +1.
- sw (101011), mem_rdy=1, then beq (000100), then jalr (000000/001001) -> states 0,1,2,5,0,1,8,0,1,9,0; retired +3; instr_done high in the MW, Branch and Jump cycles.
- Opcode 111111, then opcode 000000 with funct 000000 -> each gives state 0,1,0 with illegal=1 in the IF cycle; retired unchanged; no instr_done.
- rst asserted during MR while mem_rdy=0 with retired=5 -> next cycle state=0, retired=0, illegal=0; the following instruction sequences normally.
- CNT_W=2, run 5 ori (001101) instructions -> retired reads 1,2,3,0,1 after each completion.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: 4-bit state register advanced by opcode/funct; instr_done is combinational, illegal and retired are registered.
// Stalls in MR/MW while mem_rdy=0; no other backpressure.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_rdy,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_MA     = 4'b0010,
        S_MR     = 4'b0011,
        S_MEMWB  = 4'b0100,
        S_MW     = 4'b0101,
        S_EXE    = 4'b0110,
        S_WB     = 4'b0111,
        S_BRANCH = 4'b1000,
        S_JUMP   = 4'b1001
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic is_load, is_store, is_imm, is_r_alu, is_r_jump, is_jump;

    always_comb begin
        is_load   = (opcode == OP_LW) || (opcode == OP_LB);
        is_store  = (opcode == OP_SW) || (opcode == OP_SB);
        is_imm    = (opcode == OP_ADDI) || (opcode == OP_ADDIU) ||
                    (opcode == OP_ORI)  || (opcode == OP_LUI);
        is_r_alu  = (opcode == OP_RTYPE) &&
                    ((funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_SLT));
        is_r_jump = (opcode == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));
        is_jump   = (opcode == OP_J) || (opcode == OP_JAL) || is_r_jump;
    end

    // Completion is a function of state and mem_rdy only, so the decoder sees it in the same cycle.
    always_comb begin
        instr_done = 1'b0;
        case (state_q)
            S_MEMWB, S_WB, S_BRANCH, S_JUMP: instr_done = 1'b1;
            S_MW:                            instr_done = mem_rdy;
            default:                         instr_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        retired_d = retired_q + CNT_W'(instr_done);
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (is_load || is_store)       state_d = S_MA;
                else if (is_imm || is_r_alu)   state_d = S_EXE;
                else if (opcode == OP_BEQ)     state_d = S_BRANCH;
                else if (is_jump)              state_d = S_JUMP;
                else begin
                    state_d   = S_IF;
                    illegal_d = 1'b1;
                end
            end
            // Opcode cannot change after ID in practice; the fall-through to IF is defensive.
            S_MA: begin
                if (is_load)       state_d = S_MR;
                else if (is_store) state_d = S_MW;
                else               state_d = S_IF;
            end
            S_MR:     state_d = mem_rdy ? S_MEMWB : S_MR;
            S_MEMWB:  state_d = S_IF;
            S_MW:     state_d = mem_rdy ? S_IF : S_MW;
            S_EXE:    state_d = S_WB;
            S_WB:     state_d = S_IF;
            S_BRANCH: state_d = S_IF;
            S_JUMP:   state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: cycle-by-cycle vector table plus a counter-wrap sequence on a CNT_W=2 instance.
module tb_mc_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_rdy;
    logic [3:0]  state, state_s;
    logic        instr_done, instr_done_s;
    logic        illegal, illegal_s;
    logic [31:0] retired;
    logic [1:0]  retired_s;

    int n_vec;
    int n_err;

    mc_ctrl_fsm #(.CNT_W(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .mem_rdy    (mem_rdy),
        .state      (state),
        .instr_done (instr_done),
        .illegal    (illegal),
        .retired    (retired)
    );

    mc_ctrl_fsm #(.CNT_W(2)) u_small (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .mem_rdy    (mem_rdy),
        .state      (state_s),
        .instr_done (instr_done_s),
        .illegal    (illegal_s),
        .retired    (retired_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic [3:0]  st;
        logic        done;
        logic        ill;
        logic [31:0] ret;
    } vec_t;

    vec_t vq[$];

    localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, SW = 6'b101011, SB = 6'b101000;
    localparam logic [5:0] ORI = 6'b001101, BEQ = 6'b000100, J = 6'b000010, RT = 6'b000000;
    localparam logic [5:0] ADDU = 6'b100001, JALR = 6'b001001;

    function automatic void add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                input logic rdy, input logic [3:0] st, input logic done,
                                input logic ill, input logic [31:0] ret);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.rdy = rdy;
        v.st = st; v.done = done; v.ill = ill; v.ret = ret;
        vq.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ret(input string name, input logic [31:0] exp_w, input logic [1:0] exp_s);
        n_vec++;
        if (retired !== exp_w || retired_s !== exp_s) begin
            n_err++;
            $display("FAIL %s: retired=%0d small=%0d, required %0d / %0d",
                     name, retired, retired_s, exp_w, exp_s);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; opcode = 6'b0; funct = 6'b0; mem_rdy = 1'b1;

        // addu: 0,1,6,7
        add(0, RT, ADDU, 1, 4'd0, 0, 0, 0);
        add(0, RT, ADDU, 1, 4'd1, 0, 0, 0);
        add(0, RT, ADDU, 1, 4'd6, 0, 0, 0);
        add(0, RT, ADDU, 1, 4'd7, 1, 0, 0);
        // lw with two stall cycles; mem_rdy low in IF/ID/MA is ignored
        add(0, LW, 0, 0, 4'd0, 0, 0, 1);
        add(0, LW, 0, 0, 4'd1, 0, 0, 1);
        add(0, LW, 0, 0, 4'd2, 0, 0, 1);
        add(0, LW, 0, 0, 4'd3, 0, 0, 1);
        add(0, LW, 0, 0, 4'd3, 0, 0, 1);
        add(0, LW, 0, 1, 4'd3, 0, 0, 1);
        add(0, LW, 0, 1, 4'd4, 1, 0, 1);
        // sw, beq, jalr
        add(0, SW, 0, 1, 4'd0, 0, 0, 2);
        add(0, SW, 0, 1, 4'd1, 0, 0, 2);
        add(0, SW, 0, 1, 4'd2, 0, 0, 2);
        add(0, SW, 0, 1, 4'd5, 1, 0, 2);
        add(0, BEQ, 0, 1, 4'd0, 0, 0, 3);
        add(0, BEQ, 0, 1, 4'd1, 0, 0, 3);
        add(0, BEQ, 0, 1, 4'd8, 1, 0, 3);
        add(0, RT, JALR, 1, 4'd0, 0, 0, 4);
        add(0, RT, JALR, 1, 4'd1, 0, 0, 4);
        add(0, RT, JALR, 1, 4'd9, 1, 0, 4);
        // two illegal instructions
        add(0, 6'b111111, 0, 1, 4'd0, 0, 0, 5);
        add(0, 6'b111111, 0, 1, 4'd1, 0, 0, 5);
        add(0, RT, 6'b000000, 1, 4'd0, 0, 1, 5);
        add(0, RT, 6'b000000, 1, 4'd1, 0, 0, 5);
        // lw interrupted by reset while stalled in MR
        add(0, LW, 0, 1, 4'd0, 0, 1, 5);
        add(0, LW, 0, 1, 4'd1, 0, 0, 5);
        add(0, LW, 0, 1, 4'd2, 0, 0, 5);
        add(0, LW, 0, 0, 4'd3, 0, 0, 5);
        add(1, LW, 0, 0, 4'd3, 0, 0, 5);
        // ori after reset; opcode change in Exe has no effect
        add(0, ORI, 0, 1, 4'd0, 0, 0, 0);
        add(0, ORI, 0, 1, 4'd1, 0, 0, 0);
        add(0, LW, 0, 1, 4'd6, 0, 0, 0);
        add(0, LW, 0, 1, 4'd7, 1, 0, 0);
        // sb with one MW stall
        add(0, SB, 0, 1, 4'd0, 0, 0, 1);
        add(0, SB, 0, 1, 4'd1, 0, 0, 1);
        add(0, SB, 0, 1, 4'd2, 0, 0, 1);
        add(0, SB, 0, 0, 4'd5, 0, 0, 1);
        add(0, SB, 0, 1, 4'd5, 1, 0, 1);
        // j, then lb without stall
        add(0, J, 0, 1, 4'd0, 0, 0, 2);
        add(0, J, 0, 1, 4'd1, 0, 0, 2);
        add(0, J, 0, 1, 4'd9, 1, 0, 2);
        add(0, LB, 0, 1, 4'd0, 0, 0, 3);
        add(0, LB, 0, 1, 4'd1, 0, 0, 3);
        add(0, LB, 0, 1, 4'd2, 0, 0, 3);
        add(0, LB, 0, 1, 4'd3, 0, 0, 3);
        add(0, LB, 0, 1, 4'd4, 1, 0, 3);
        add(0, 6'b0, 0, 1, 4'd0, 0, 0, 4);

        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            rst     = vq[i].rst;
            opcode  = vq[i].op;
            funct   = vq[i].fn;
            mem_rdy = vq[i].rdy;
            #4;
            n_vec++;
            if (state !== vq[i].st || instr_done !== vq[i].done || illegal !== vq[i].ill ||
                retired !== vq[i].ret || retired_s !== vq[i].ret[1:0]) begin
                n_err++;
                $display("FAIL vec%0d: state=%0d done=%b ill=%b ret=%0d small=%0d, required state=%0d done=%b ill=%b ret=%0d",
                         i, state, instr_done, illegal, retired, retired_s,
                         vq[i].st, vq[i].done, vq[i].ill, vq[i].ret);
            end
            step();
        end

        // Counter wrap on the 2-bit instance: five ori instructions.
        rst = 1'b1;
        step();
        rst = 1'b0;
        opcode = ORI; funct = 6'b0; mem_rdy = 1'b1;
        check_ret("wrap_reset", 32'd0, 2'd0);
        for (int k = 1; k <= 5; k++) begin
            for (int c = 0; c < 4; c++) step();
            check_ret($sformatf("wrap_%0d", k), 32'(k), 2'(k % 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
